// File: rtl/motion_sequencer_pkg.sv
// Shared types for the motion sequencer: FSM states, axis indices,
// step word geometry and the queued move record.
package motion_pkg;

  localparam int STEP_W   = 32;
  localparam int SIGN_BIT = STEP_W - 1;

  localparam int AXIS_X = 0;
  localparam int AXIS_Y = 1;
  localparam int AXIS_Z = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_CHECK     = 3'd4,
    ST_FAULT     = 3'd5
  } state_e;

  // One queued move: three signed step counts plus the half-period speed.
  typedef struct packed {
    logic signed [STEP_W-1:0] z_step;
    logic signed [STEP_W-1:0] y_step;
    logic signed [STEP_W-1:0] x_step;
    logic        [STEP_W-1:0] speed;
  } move_t;

  // An axis takes part in a move unless its magnitude bits are all zero
  // (covers both +0 and the bare direction bit 32'h8000_0000).
  function automatic logic axis_active(input logic signed [STEP_W-1:0] step);
    return step[SIGN_BIT-1:0] != '0;
  endfunction

endpackage

// File: rtl/motion_sequencer_cmd_fifo.sv
// Move FIFO between the command decoder and the sequencer FSM.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module cmd_fifo
  import motion_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  move_t push_data,
  input  logic  pop,
  input  logic  flush,
  output move_t head,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  move_t       mem [FIFO_DEPTH];

  // Pointer control; flush discards everything including a same-cycle push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is data only and needs no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/motion_sequencer.sv
// Three-axis move sequencer: pops queued moves, strobes the participating
// stepper channels together, waits for all of them, and latches a fault on
// a short move or an abort until software clears it.
module motion_sequencer
  import motion_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic signed [STEP_W-1:0] cmd_x_step,
  input  logic signed [STEP_W-1:0] cmd_y_step,
  input  logic signed [STEP_W-1:0] cmd_z_step,
  input  logic        [STEP_W-1:0] cmd_speed,
  input  logic                     abort,
  input  logic                     fault_clear,
  output logic signed [STEP_W-1:0] x_step_in,
  output logic signed [STEP_W-1:0] y_step_in,
  output logic signed [STEP_W-1:0] z_step_in,
  output logic        [STEP_W-1:0] x_speed,
  output logic        [STEP_W-1:0] y_speed,
  output logic        [STEP_W-1:0] z_speed,
  output logic                     x_start,
  output logic                     y_start,
  output logic                     z_start,
  output logic                     stepper_enable,
  input  logic                     x_driving,
  input  logic                     y_driving,
  input  logic                     z_driving,
  input  logic signed [STEP_W-1:0] x_step_rem,
  input  logic signed [STEP_W-1:0] y_step_rem,
  input  logic signed [STEP_W-1:0] z_step_rem,
  output logic                     busy,
  output logic                     fault,
  output logic [2:0]               fault_axis,
  output logic                     fault_abort,
  output logic [CNT_W-1:0]         moves_done
);

  state_e     state;
  logic [2:0] mask;
  logic [2:0] start_vec;

  move_t      cmd_move;
  move_t      head;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_flush;
  logic       fifo_full;
  logic       fifo_empty;

  logic       abort_hit;
  logic [2:0] head_mask;
  logic [2:0] driving_vec;
  logic [2:0] rem_nz;
  logic [2:0] short_axes;

  assign cmd_move = '{z_step: cmd_z_step, y_step: cmd_y_step,
                      x_step: cmd_x_step, speed: cmd_speed};

  // Per-axis views of the FIFO head and the channel status, indexed by axis.
  always_comb begin
    head_mask           = '0;
    driving_vec         = '0;
    rem_nz              = '0;
    head_mask[AXIS_X]   = axis_active(head.x_step);
    head_mask[AXIS_Y]   = axis_active(head.y_step);
    head_mask[AXIS_Z]   = axis_active(head.z_step);
    driving_vec[AXIS_X] = x_driving;
    driving_vec[AXIS_Y] = y_driving;
    driving_vec[AXIS_Z] = z_driving;
    rem_nz[AXIS_X]      = (x_step_rem != '0);
    rem_nz[AXIS_Y]      = (y_step_rem != '0);
    rem_nz[AXIS_Z]      = (z_step_rem != '0);
  end

  assign short_axes = mask & rem_nz;
  assign abort_hit  = abort && (state != ST_FAULT);
  assign cmd_ready  = !fifo_full && (state != ST_FAULT) && !abort;
  assign busy       = !((state == ST_IDLE) && fifo_empty);
  assign fifo_push  = cmd_valid && cmd_ready;
  assign fifo_pop   = (state == ST_IDLE) && !fifo_empty && !abort;
  assign fifo_flush = abort_hit || ((state == ST_CHECK) && (short_axes != '0));

  cmd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (cmd_move),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign x_start = start_vec[AXIS_X];
  assign y_start = start_vec[AXIS_Y];
  assign z_start = start_vec[AXIS_Z];

  // Sequencer FSM with registered channel outputs; abort overrides every
  // non-FAULT state, a short move overrides completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      mask           <= '0;
      start_vec      <= '0;
      x_step_in      <= '0;
      y_step_in      <= '0;
      z_step_in      <= '0;
      x_speed        <= '0;
      y_speed        <= '0;
      z_speed        <= '0;
      stepper_enable <= 1'b1;
      fault          <= 1'b0;
      fault_axis     <= '0;
      fault_abort    <= 1'b0;
      moves_done     <= '0;
    end else begin
      start_vec <= '0;
      if (abort_hit) begin
        state          <= ST_FAULT;
        fault          <= 1'b1;
        fault_abort    <= 1'b1;
        stepper_enable <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (!fifo_empty) begin
              x_step_in <= head.x_step;
              y_step_in <= head.y_step;
              z_step_in <= head.z_step;
              x_speed   <= head.speed;
              y_speed   <= head.speed;
              z_speed   <= head.speed;
              mask      <= head_mask;
              if (head_mask == '0) begin
                state <= ST_CHECK;
              end else begin
                state     <= ST_ISSUE;
                start_vec <= head_mask;
              end
            end
          end
          ST_ISSUE:     state <= ST_WAIT_ACK;
          ST_WAIT_ACK:  state <= ST_WAIT_DONE;
          ST_WAIT_DONE: if ((driving_vec & mask) == '0) state <= ST_CHECK;
          ST_CHECK: begin
            if (short_axes != '0) begin
              state          <= ST_FAULT;
              fault          <= 1'b1;
              fault_axis     <= short_axes;
              stepper_enable <= 1'b0;
            end else begin
              state      <= ST_IDLE;
              moves_done <= moves_done + CNT_W'(1);
            end
          end
          ST_FAULT: begin
            if (fault_clear) begin
              state          <= ST_IDLE;
              fault          <= 1'b0;
              fault_axis     <= '0;
              fault_abort    <= 1'b0;
              stepper_enable <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_motion_sequencer.sv
// Bench for motion_sequencer: channel models, a queue-based reference of the
// sequencing rules, directed scenarios and a randomized run.
module tb_motion_sequencer;

  localparam int DEPTH = 4;
  localparam int CW    = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready, abort, fault_clear;
  logic [31:0] cmd_x_step, cmd_y_step, cmd_z_step, cmd_speed;
  logic [31:0] x_step_in, y_step_in, z_step_in, x_speed, y_speed, z_speed;
  logic        x_start, y_start, z_start, stepper_enable;
  logic        x_driving, y_driving, z_driving;
  logic [31:0] x_step_rem, y_step_rem, z_step_rem;
  logic        busy, fault, fault_abort;
  logic [2:0]  fault_axis;
  logic [CW-1:0] moves_done;

  always #5 clk = ~clk;

  motion_sequencer #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x_step(cmd_x_step), .cmd_y_step(cmd_y_step), .cmd_z_step(cmd_z_step),
    .cmd_speed(cmd_speed), .abort(abort), .fault_clear(fault_clear),
    .x_step_in(x_step_in), .y_step_in(y_step_in), .z_step_in(z_step_in),
    .x_speed(x_speed), .y_speed(y_speed), .z_speed(z_speed),
    .x_start(x_start), .y_start(y_start), .z_start(z_start),
    .stepper_enable(stepper_enable),
    .x_driving(x_driving), .y_driving(y_driving), .z_driving(z_driving),
    .x_step_rem(x_step_rem), .y_step_rem(y_step_rem), .z_step_rem(z_step_rem),
    .busy(busy), .fault(fault), .fault_axis(fault_axis),
    .fault_abort(fault_abort), .moves_done(moves_done)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // ---------------- channel models ----------------
  int          dur_lo = 2, dur_hi = 6;
  logic [31:0] short_rem [3];
  logic        drv [3];
  logic [31:0] rem [3];
  logic [31:0] shr [3];
  int          cnt [3];

  function automatic logic chan_idle();
    return !(x_driving || y_driving || z_driving);
  endfunction

  initial begin
    logic [2:0] st;
    for (int i = 0; i < 3; i++) begin
      drv[i] = 1'b0; rem[i] = '0; shr[i] = '0; cnt[i] = 0; short_rem[i] = '0;
    end
    x_driving = 0; y_driving = 0; z_driving = 0;
    x_step_rem = 0; y_step_rem = 0; z_step_rem = 0;
    forever begin
      @(posedge clk); #1;
      st = {z_start, y_start, x_start};
      for (int i = 0; i < 3; i++) begin
        if (cnt[i] != 0) begin
          cnt[i]--;
          if (cnt[i] == 0) begin drv[i] = 1'b0; rem[i] = shr[i]; end
        end
        if (st[i]) begin
          drv[i] = 1'b1;
          cnt[i] = $urandom_range(dur_hi, dur_lo);
          shr[i] = short_rem[i];
          rem[i] = 32'd1000;
        end
      end
      x_driving = drv[0]; y_driving = drv[1]; z_driving = drv[2];
      x_step_rem = rem[0]; y_step_rem = rem[1]; z_step_rem = rem[2];
    end
  end

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] x, y, z, s; } mv_t;
  mv_t         mq [$];
  logic [31:0] m_x, m_y, m_z, m_s;
  logic [2:0]  m_start, m_mask, m_fax;
  logic        m_en, m_fault, m_fab, m_in, m_check;
  int          m_age;
  logic [CW-1:0] m_done;

  function automatic logic takes_part(input logic [31:0] v);
    return (v != 32'h0) && (v != 32'h8000_0000);
  endfunction

  function automatic logic [2:0] mask_of(input mv_t m);
    return {takes_part(m.z), takes_part(m.y), takes_part(m.x)};
  endfunction

  task automatic m_reset();
    mq.delete();
    m_x = 0; m_y = 0; m_z = 0; m_s = 0; m_start = 0; m_mask = 0; m_fax = 0;
    m_en = 1; m_fault = 0; m_fab = 0; m_in = 0; m_check = 0; m_age = 0; m_done = 0;
  endtask

  always @(negedge clk) begin
    logic       exp_ready, push;
    logic [2:0] drv_v, rem_nz, sh;
    mv_t        mv, cur;
    if (!rst_n) m_reset();
    exp_ready = (mq.size() < DEPTH) && !m_fault && !abort;
    chk("cmd_ready", cmd_ready, exp_ready);
    chk("busy", busy, m_in || m_fault || (mq.size() != 0));
    chk("start", {z_start, y_start, x_start}, m_start);
    chk("x_step_in", x_step_in, m_x);
    chk("y_step_in", y_step_in, m_y);
    chk("z_step_in", z_step_in, m_z);
    chk("speed", {x_speed ^ m_s, y_speed ^ m_s, z_speed ^ m_s} == '0, 1'b1);
    chk("stepper_enable", stepper_enable, m_en);
    chk("fault", fault, m_fault);
    chk("fault_axis", fault_axis, m_fax);
    chk("fault_abort", fault_abort, m_fab);
    chk("moves_done", moves_done, m_done);
    if (rst_n) begin
      push   = cmd_valid && exp_ready;
      mv     = '{cmd_x_step, cmd_y_step, cmd_z_step, cmd_speed};
      drv_v  = {z_driving, y_driving, x_driving};
      rem_nz = {z_step_rem != 0, y_step_rem != 0, x_step_rem != 0};
      m_start = '0;
      if (abort && !m_fault) begin
        m_fault = 1; m_fab = 1; m_en = 0; mq.delete(); m_in = 0; m_check = 0;
      end else if (m_fault) begin
        if (fault_clear) begin m_fault = 0; m_fab = 0; m_fax = 0; m_en = 1; end
      end else if (m_in) begin
        if (m_check) begin
          sh = m_mask & rem_nz;
          m_in = 0; m_check = 0;
          if (sh != 0) begin
            m_fault = 1; m_fax = sh; m_en = 0; mq.delete(); push = 0;
          end else begin
            m_done++;
          end
        end else begin
          if (m_age >= 3 && (drv_v & m_mask) == 0) m_check = 1;
          m_age++;
        end
      end else if (mq.size() != 0) begin
        cur = mq.pop_front();
        m_x = cur.x; m_y = cur.y; m_z = cur.z; m_s = cur.s;
        m_mask = mask_of(cur); m_start = m_mask;
        m_in = 1; m_age = 1; m_check = (m_mask == 0);
      end
      if (push) mq.push_back(mv);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_move(input logic [31:0] x, y, z, s, output int stalls);
    logic acc;
    acc = 0; stalls = 0;
    cmd_valid = 1; cmd_x_step = x; cmd_y_step = y; cmd_z_step = z; cmd_speed = s;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk); acc = cmd_ready;
      @(posedge clk); #1;
      if (acc) break;
      stalls++;
    end
    cmd_valid = 0;
    if (!acc) bound_fail("push_move");
  endtask

  task automatic settle(input logic clr);
    logic ok;
    ok = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!busy && chan_idle()) begin ok = 1; break; end
      if (clr && fault) begin
        @(posedge clk); #1 fault_clear = 1;
        @(posedge clk); #1 fault_clear = 0;
      end
    end
    @(posedge clk); #1;
    if (!ok) bound_fail("settle");
  endtask

  function automatic logic [31:0] rnd_step();
    case ($urandom_range(4, 0))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2, 3:    return $urandom_range(400, 0) - 200;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, tot;
    logic ok;
    cmd_valid = 0; cmd_x_step = 0; cmd_y_step = 0; cmd_z_step = 0; cmd_speed = 0;
    abort = 0; fault_clear = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // reset state
    @(negedge clk);
    chk("rst_step", x_step_in, 32'h0);
    chk("rst_enable", stepper_enable, 1'b1);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", moves_done, 8'h0);
    @(posedge clk); #1;

    // single move: X=100, Y=-50, Z=0
    push_move(32'd100, -32'sd50, 32'd0, 32'd4, st);
    @(posedge clk); @(negedge clk);
    chk("single_start", {z_start, y_start, x_start}, 3'b011);
    chk("single_x", x_step_in, 32'd100);
    chk("single_y", y_step_in, 32'hFFFF_FFCE);
    @(negedge clk);
    chk("single_start_off", {z_start, y_start, x_start}, 3'b000);
    @(posedge clk); #1;
    settle(0);
    chk("single_done", moves_done, 8'd1);
    chk("single_busy", busy, 1'b0);

    // zero move counts two cycles after the pop
    push_move(32'd0, 32'd0, 32'd0, 32'd1, st);
    @(negedge clk);
    chk("zero_pop_done", moves_done, 8'd1);
    @(negedge clk);
    chk("zero_check_done", moves_done, 8'd1);
    chk("zero_nostart", {z_start, y_start, x_start}, 3'b000);
    @(negedge clk);
    chk("zero_done", moves_done, 8'd2);
    @(posedge clk); #1;
    push_move(32'h8000_0000, 32'd0, 32'h8000_0000, 32'd5, st);
    settle(0);
    chk("signzero_done", moves_done, 8'd3);

    // queue of six moves with back-pressure
    dur_lo = 3; dur_hi = 6; tot = 0;
    for (int i = 0; i < 6; i++) begin
      push_move(32'(i * 10 + 1), -32'(i + 1), 32'(i + 2), 32'(i + 1), st);
      tot += st;
    end
    chk("queue_backpressure", tot > 0, 1'b1);
    settle(0);
    chk("queue_done", moves_done, 8'd9);

    // endstop on Z
    short_rem[2] = 32'd7;
    push_move(32'd5, 32'd0, 32'd30, 32'd2, st);
    push_move(32'd6, 32'd0, 32'd31, 32'd2, st);
    push_move(32'd7, 32'd0, 32'd32, 32'd2, st);
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (fault) begin ok = 1; break; end
    end
    if (!ok) bound_fail("endstop_wait");
    chk("endstop_axis", fault_axis, 3'b100);
    chk("endstop_enable", stepper_enable, 1'b0);
    chk("endstop_ready", cmd_ready, 1'b0);
    short_rem[2] = 32'd0;
    @(posedge clk); #1 fault_clear = 1;
    @(posedge clk); #1 fault_clear = 0;
    @(negedge clk);
    chk("clear_fault", fault, 1'b0);
    chk("clear_ready", cmd_ready, 1'b1);
    chk("clear_flushed", busy, 1'b0);
    @(posedge clk); #1;
    settle(0);

    // abort during WAIT_DONE with two moves queued
    dur_lo = 20; dur_hi = 25;
    push_move(32'd40, 32'd0, 32'd0, 32'd3, st);
    push_move(32'd41, 32'd1, 32'd0, 32'd3, st);
    push_move(32'd42, 32'd2, 32'd0, 32'd3, st);
    repeat (3) begin @(posedge clk); #1; end
    abort = 1;
    #1 chk("abort_ready", cmd_ready, 1'b0);
    @(posedge clk); #1 abort = 0;
    @(negedge clk);
    chk("abort_enable", stepper_enable, 1'b0);
    chk("abort_flag", fault_abort, 1'b1);
    tot = 0;
    repeat (10) begin
      @(negedge clk);
      if ({z_start, y_start, x_start} != 0) tot++;
    end
    chk("abort_no_strobes", tot, 0);
    @(posedge clk); #1;
    settle(1);
    chk("abort_done", moves_done, 8'd9);

    // reset in mid-move
    dur_lo = 20; dur_hi = 25;
    push_move(32'd10, 32'd0, 32'd0, 32'd2, st);
    repeat (4) begin @(posedge clk); #1; end
    #1 rst_n = 0;
    #1;
    chk("midrst_step", x_step_in, 32'h0);
    chk("midrst_start", {z_start, y_start, x_start}, 3'b000);
    chk("midrst_enable", stepper_enable, 1'b1);
    chk("midrst_ready", cmd_ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", moves_done, 8'h0);
    @(posedge clk); #1 rst_n = 1;
    settle(0);

    // counter wrap
    for (int i = 0; i < 255; i++) push_move(32'd0, 32'h8000_0000, 32'd0, 32'd1, st);
    settle(0);
    chk("wrap_full", moves_done, 8'hFF);
    push_move(32'd0, 32'd0, 32'd0, 32'd1, st);
    settle(0);
    chk("wrap_zero", moves_done, 8'h00);

    // randomized traffic
    dur_lo = 1; dur_hi = 8;
    for (int c = 0; c < 3000; c++) begin
      cmd_valid   = ($urandom_range(3, 0) != 0);
      cmd_x_step  = rnd_step();
      cmd_y_step  = rnd_step();
      cmd_z_step  = rnd_step();
      cmd_speed   = $urandom_range(50, 1);
      abort       = ($urandom_range(199, 0) == 0);
      fault_clear = fault ? ($urandom_range(3, 0) == 0) : ($urandom_range(49, 0) == 0);
      for (int i = 0; i < 3; i++)
        short_rem[i] = ($urandom_range(24, 0) == 0) ? $urandom_range(100, 1) : 32'd0;
      @(posedge clk); #1;
    end
    cmd_valid = 0; abort = 0; fault_clear = 0;
    for (int i = 0; i < 3; i++) short_rem[i] = 32'd0;
    settle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
